// File: rtl/shared_mem_bus_ctrl.sv
// rtl/shared_mem_bus_ctrl.sv - round-robin arbiter sharing one single-port memory between cores
module shared_mem_bus_ctrl #(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CORES-1:0]            core_req,
  input  logic [NUM_CORES-1:0]            core_we,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] core_wdata,
  output logic [NUM_CORES-1:0]            core_ack,
  output logic                            core_err,
  output logic [DATA_WIDTH-1:0]           core_rdata,
  output logic [NUM_CORES-1:0]            core_grant,
  output logic                            mem_req,
  output logic                            mem_we,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic                            mem_ack,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  output logic                            busy
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  // count only has to reach TIMEOUT-1
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        prio_ptr_q, prio_ptr_d;
  logic [PTR_W-1:0]        grant_idx_q, grant_idx_d;
  logic [CNT_W-1:0]        count_q, count_d;

  logic [NUM_CORES-1:0]    core_ack_d;
  logic                    core_err_d;
  logic [DATA_WIDTH-1:0]   core_rdata_d;
  logic [NUM_CORES-1:0]    core_grant_d;
  logic                    mem_req_d;
  logic                    mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_d;
  logic                    busy_d;

  logic                    sel_found;
  logic [PTR_W-1:0]        sel_idx;

  // wrap an index back into the core range (handles non power-of-two counts)
  function automatic logic [PTR_W-1:0] wrap_idx(input int v);
    return PTR_W'(v % NUM_CORES);
  endfunction

  // round-robin pick: first requester at or after prio_ptr
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!sel_found && core_req[wrap_idx(int'(prio_ptr_q) + k)]) begin
        sel_found = 1'b1;
        sel_idx   = wrap_idx(int'(prio_ptr_q) + k);
      end
    end
  end

  // next-state and next registered-output computation
  always_comb begin
    state_d      = state_q;
    prio_ptr_d   = prio_ptr_q;
    grant_idx_d  = grant_idx_q;
    count_d      = count_q;
    core_ack_d   = '0;
    core_err_d   = 1'b0;
    core_rdata_d = '0;
    core_grant_d = core_grant;
    mem_req_d    = mem_req;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    busy_d       = busy;

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d      = ISSUE;
          grant_idx_d  = sel_idx;
          core_grant_d = {{(NUM_CORES-1){1'b0}}, 1'b1} << sel_idx;
          count_d      = '0;
          mem_req_d    = 1'b1;
          mem_we_d     = core_we[sel_idx];
          mem_addr_d   = core_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata_d  = core_wdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
          busy_d       = 1'b1;
        end
      end

      ISSUE: begin
        // an ack on the final allowed cycle still counts as success
        if (mem_ack) begin
          state_d      = RESP;
          mem_req_d    = 1'b0;
          core_ack_d   = core_grant;
          core_err_d   = 1'b0;
          core_rdata_d = mem_we ? '0 : mem_rdata;
        end else if (count_q == CNT_W'(TIMEOUT - 1)) begin
          state_d      = RESP;
          mem_req_d    = 1'b0;
          core_ack_d   = core_grant;
          core_err_d   = 1'b1;
          core_rdata_d = '0;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end

      RESP: begin
        state_d      = IDLE;
        prio_ptr_d   = wrap_idx(int'(grant_idx_q) + 1);
        core_grant_d = '0;
        count_d      = '0;
        busy_d       = 1'b0;
      end

      default: begin
        state_d      = IDLE;
        core_grant_d = '0;
        mem_req_d    = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  // state and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      prio_ptr_q  <= '0;
      grant_idx_q <= '0;
      count_q     <= '0;
      core_ack    <= '0;
      core_err    <= 1'b0;
      core_rdata  <= '0;
      core_grant  <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_ptr_q  <= prio_ptr_d;
      grant_idx_q <= grant_idx_d;
      count_q     <= count_d;
      core_ack    <= core_ack_d;
      core_err    <= core_err_d;
      core_rdata  <= core_rdata_d;
      core_grant  <= core_grant_d;
      mem_req     <= mem_req_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_shared_mem_bus_ctrl.sv
// tb/tb_shared_mem_bus_ctrl.sv - directed scoreboard bench for shared_mem_bus_ctrl
module tb_shared_mem_bus_ctrl;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NC-1:0]    core_req = '0;
  logic [NC-1:0]    core_we = '0;
  logic [NC*AW-1:0] core_addr;
  logic [NC*DW-1:0] core_wdata;
  logic [NC-1:0]    core_ack;
  logic             core_err;
  logic [DW-1:0]    core_rdata;
  logic [NC-1:0]    core_grant;
  logic             mem_req;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_ack = 1'b0;
  logic [DW-1:0]    mem_rdata = 32'hBAADF00D;
  logic             busy;

  logic [AW-1:0]    c_addr  [NC];
  logic [DW-1:0]    c_wdata [NC];

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [NC-1:0] grant;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : g_pack
    assign core_addr[g*AW +: AW]  = c_addr[g];
    assign core_wdata[g*DW +: DW] = c_wdata[g];
  end

  shared_mem_bus_ctrl #(
    .NUM_CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_err(core_err), .core_rdata(core_rdata), .core_grant(core_grant),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int core, input logic err, input logic [DW-1:0] rdata);
    exp_t e;
    e.grant = NC'(1) << core;
    e.we    = core_we[core];
    e.addr  = c_addr[core];
    e.wdata = c_wdata[core];
    e.err   = err;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  // play memory for one transaction: ack on cycle ack_cycle of mem_req (0 = never)
  task automatic serve(input int ack_cycle, input logic [DW-1:0] rd);
    exp_t e;
    int w;
    int hi;
    e = sb.pop_front();
    w = 0;
    while (mem_req !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("mem_req_rise_bound", 64'(w < 20), 64'd1);
    hi = 0;
    while (mem_req === 1'b1 && hi < 20) begin
      hi++;
      chk("issue_grant", 64'(core_grant), 64'(e.grant));
      chk("issue_we", 64'(mem_we), 64'(e.we));
      chk("issue_addr", 64'(mem_addr), 64'(e.addr));
      chk("issue_wdata", 64'(mem_wdata), 64'(e.wdata));
      chk("issue_busy", 64'(busy), 64'd1);
      if (hi == ack_cycle) begin
        mem_ack   = 1'b1;
        mem_rdata = rd;
      end
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'hBAADF00D;
    end
    chk("mem_req_cycles", 64'(hi), 64'((ack_cycle == 0) ? TO : ack_cycle));
    chk("resp_ack", 64'(core_ack), 64'(e.grant));
    chk("resp_err", 64'(core_err), 64'(e.err));
    chk("resp_rdata", 64'(core_rdata), 64'(e.rdata));
    chk("resp_grant", 64'(core_grant), 64'(e.grant));
    @(negedge clk);
    chk("post_ack", 64'(core_ack), 64'd0);
    chk("post_grant", 64'(core_grant), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin
      c_addr[i]  = 32'h1000 + 32'(i * 16);
      c_wdata[i] = 32'hA0A0_0000 + 32'(i);
    end

    // reset state
    #1;
    chk("rst_ack", 64'(core_ack), 64'd0);
    chk("rst_grant", 64'(core_grant), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_rdata", 64'(core_rdata), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // all cores requesting: grants rotate 0,1,2,3,0
    core_req = 4'hF;
    push_exp(0, 1'b0, 32'h0000_1000);
    push_exp(1, 1'b0, 32'h0000_1001);
    push_exp(2, 1'b0, 32'h0000_1002);
    push_exp(3, 1'b0, 32'h0000_1003);
    push_exp(0, 1'b0, 32'h0000_1004);
    serve(1, 32'h0000_1000);
    serve(2, 32'h0000_1001);
    serve(1, 32'h0000_1002);
    serve(3, 32'h0000_1003);
    serve(1, 32'h0000_1004);
    core_req = '0;
    @(negedge clk);

    // single read from core 2
    c_addr[2] = 32'h40;
    core_req  = 4'b0100;
    push_exp(2, 1'b0, 32'hDEADBEEF);
    serve(2, 32'hDEADBEEF);
    core_req = '0;
    @(negedge clk);

    // core 1 write; memory drives junk rdata that must not be returned
    c_addr[1]  = 32'h8;
    c_wdata[1] = 32'h12345678;
    core_we    = 4'b0010;
    core_req   = 4'b0010;
    push_exp(1, 1'b0, 32'h0);
    serve(3, 32'hCAFEF00D);
    core_req = '0;
    core_we  = '0;
    @(negedge clk);

    // core 3 timeout, then ptr must have moved past core 3
    core_req = 4'b1000;
    push_exp(3, 1'b1, 32'h0);
    serve(0, 32'h0);
    core_req = 4'b1001;
    push_exp(0, 1'b0, 32'h5555_0000);
    serve(1, 32'h5555_0000);
    core_req = '0;
    @(negedge clk);

    // ack on the final allowed issue cycle wins
    core_req = 4'b0100;
    push_exp(2, 1'b0, 32'h0BAD_CAFE);
    serve(TO, 32'h0BAD_CAFE);
    core_req = '0;
    @(negedge clk);

    // reset during ISSUE aborts without ack
    core_req = 4'b0100;
    begin
      int w;
      w = 0;
      while (mem_req !== 1'b1 && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("abort_issue_reached", 64'(mem_req), 64'd1);
    end
    core_req = '0;
    #2 reset = 1'b1;
    #1;
    chk("abort_mem_req", 64'(mem_req), 64'd0);
    chk("abort_grant", 64'(core_grant), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ack", 64'(core_ack), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_ack", 64'(core_ack), 64'd0);
    end
    core_req = 4'hF;
    push_exp(0, 1'b0, 32'h7777_0000);
    serve(2, 32'h7777_0000);
    core_req = '0;
    @(negedge clk);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
